zube_uart_tx: RTL

Memory-mapped UART transmitter that sits directly downstream of the bus register stage. Each accepted write to the transmit data register is delivered as a one-cycle byte strobe and queued in a small FIFO. A serialiser then drains the FIFO onto `txd` as 8N1 frames. FIFO level, busy and a sticky overflow flag are exported for the register stage to present as a readable status byte.

---
 rtl/zube_uart_tx_pkg.sv | 10 +
 rtl/zube_fifo.sv | 40 ++++
 rtl/zube_uart_tx.sv | 82 ++++++++
 3 files changed

// File: rtl/zube_uart_tx_pkg.sv
// zube_uart_tx_pkg: serialiser state encoding and 8N1 frame constants shared by the zube UART blocks.
package zube_uart_tx_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
   localparam int DATA_BITS = 8;
endpackage

// File: rtl/zube_fifo.sv
// zube_fifo: single-clock FIFO; ports clk/reset, push/din, pop/dout (head), full/empty, level (0..DEPTH).
module zube_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push, w_pop;
   // a push into a full FIFO is dropped even if a pop happens in the same cycle
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign full   = r_level == (AW+1)'(DEPTH);
   assign empty  = r_level == '0;
   assign dout   = r_mem[r_rd_ptr];
   assign level  = r_level;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr_ptr] <= din;
   always_ff @(posedge clk)
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
endmodule

// File: rtl/zube_uart_tx.sv
// zube_uart_tx: FIFO-buffered 8N1 UART transmitter; wr_valid/wr_data/wr_ready push bytes,
// clr_overflow/overflow manage the sticky drop flag, fifo_level/tx_busy report status, txd is the line.
module zube_uart_tx
   import zube_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   input  logic                          clr_overflow,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_busy,
   output logic                          txd
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_txd, r_overflow;
   logic          w_full, w_empty, w_pop, w_bit_end;
   logic [7:0]    w_head;
   zube_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_valid),
      .din   (wr_data),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (fifo_level)
   );
   assign w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);
   // pop when idle, or on the last stop cycle so the next start bit follows with no gap
   assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_bit_end));
   always_ff @(posedge clk)
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else if (w_pop) begin
         r_state <= S_START;
         r_shift <= w_head;
         r_baud  <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b0;
      end else if (r_state != S_IDLE) begin
         r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
         if (w_bit_end)
            case (r_state)
               S_START: begin
                  r_state <= S_DATA;
                  r_txd   <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
               S_DATA: begin
                  r_bit   <= r_bit + 1'b1;
                  r_state <= r_bit == 3'(DATA_BITS - 1) ? S_STOP : S_DATA;
                  r_txd   <= r_bit == 3'(DATA_BITS - 1) ? 1'b1 : r_shift[0];
                  r_shift <= r_shift >> 1;
               end
               default: r_state <= S_IDLE;
            endcase
      end
   // a drop in the same cycle as a clear leaves the flag set
   always_ff @(posedge clk)
      if (reset) r_overflow <= 1'b0;
      else if (wr_valid && w_full) r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
   assign txd      = r_txd;
   assign tx_busy  = r_state != S_IDLE;
   assign wr_ready = !w_full;
   assign overflow = r_overflow;
endmodule
